// File: rtl/mc_fsm_controller.sv
// mc_fsm_controller: multicycle processor control FSM with optional memory handshake,
// illegal-opcode trap and retired-instruction counter.
module mc_fsm_controller #(
    parameter int MEM_HANDSHAKE = 0,
    parameter int TRAP_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic             MemReady,
    output logic [3:0]       S,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             ZeroExt,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [2:0]       ALUOp,
    output logic             Trap,
    output logic [CNT_W-1:0] InstrCount
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC_R = 4'd6, RWB = 4'd7, BEQ = 4'd8, JUMP = 4'd9,
        IEXEC = 4'd10, IWB = 4'd11, BNE = 4'd12, TRAP = 4'd15
    } state_t;

    state_t state, nextState;
    logic [2:0] immAlu;
    logic hold, retire;

    assign S = state;
    assign hold = (MEM_HANDSHAKE != 0) && !MemReady;

    // Immediate ALU op is captured in DECODE so Op may change during IEXEC/IWB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            InstrCount <= '0;
            immAlu <= '0;
        end else begin
            state <= nextState;
            if (retire) InstrCount <= InstrCount + CNT_W'(1);
            if (state == DECODE) immAlu <= (Op == 6'd12) ? 3'b011 : (Op == 6'd13) ? 3'b100 : 3'b000;
        end
    end

    always_comb begin
        nextState = FETCH;
        retire = 1'b0;
        PCWrite = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe = 1'b0;
        IorD = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        IRWrite = 1'b0;
        MemToReg = 1'b0;
        RegDst = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA = 1'b0;
        ZeroExt = 1'b0;
        ALUSrcB = 2'b00;
        PCSource = 2'b00;
        ALUOp = 3'b000;
        Trap = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = !hold;
                IRWrite = !hold;
                nextState = hold ? FETCH : DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    6'd0:           nextState = EXEC_R;
                    6'd35, 6'd43:   nextState = MEMADR;
                    6'd4:           nextState = BEQ;
                    6'd5:           nextState = BNE;
                    6'd2:           nextState = JUMP;
                    6'd8, 6'd12, 6'd13: nextState = IEXEC;
                    default:        nextState = (TRAP_EN != 0) ? TRAP : FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nextState = (Op == 6'd43) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD = 1'b1;
                nextState = hold ? MEMRD : MEMWB;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                retire = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD = 1'b1;
                nextState = hold ? MEMWR : FETCH;
                retire = !hold;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp = 3'b010;
                nextState = RWB;
            end
            RWB: begin
                RegDst = 1'b1;
                RegWrite = 1'b1;
                retire = 1'b1;
            end
            BEQ, BNE: begin
                ALUSrcA = 1'b1;
                ALUOp = 3'b001;
                PCWriteCond = 1'b1;
                PCSource = 2'b01;
                BranchNe = (state == BNE);
                retire = 1'b1;
            end
            JUMP: begin
                PCWrite = 1'b1;
                PCSource = 2'b10;
                retire = 1'b1;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp = immAlu;
                ZeroExt = |immAlu;
                nextState = IWB;
            end
            IWB: begin
                RegWrite = 1'b1;
                ALUOp = immAlu;
                ZeroExt = |immAlu;
                retire = 1'b1;
            end
            TRAP: begin
                Trap = 1'b1;
                nextState = TRAP;
            end
            default: nextState = FETCH;
        endcase
    end
endmodule

// File: tb/tb_mc_fsm_controller.sv
// tb_mc_fsm_controller: scoreboard bench driving a default instance (A) and a
// handshake / no-trap / 4-bit-counter instance (B) against an instruction-level model.
module tb_mc_fsm_controller;
    typedef struct {
        bit dut;
        logic [3:0] s;
        logic [19:0] ctl;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rstA = 1'b1, rstB = 1'b1;
    logic [5:0] opA = '0, opB = '0;
    logic rdyA = 1'b0, rdyB = 1'b0;
    logic [3:0] sA, sB;
    logic [19:0] ctlA, ctlB;
    logic [15:0] cntA;
    logic [3:0] cntB;

    exp_t q[$];
    logic [4:0] cyc[$];
    int tests = 0, fails = 0;
    bit cur = 1'b0;
    logic [15:0] cnt = '0;
    logic [5:0] legal [9] = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd35, 6'd43};

    always #5 clk = ~clk;

    mc_fsm_controller dutA (
        .clk(clk), .reset(rstA), .Op(opA), .MemReady(rdyA), .S(sA),
        .PCWrite(ctlA[19]), .PCWriteCond(ctlA[18]), .BranchNe(ctlA[17]), .IorD(ctlA[16]),
        .MemRead(ctlA[15]), .MemWrite(ctlA[14]), .IRWrite(ctlA[13]), .MemToReg(ctlA[12]),
        .RegDst(ctlA[11]), .RegWrite(ctlA[10]), .ALUSrcA(ctlA[9]), .ZeroExt(ctlA[8]),
        .ALUSrcB(ctlA[7:6]), .PCSource(ctlA[5:4]), .ALUOp(ctlA[3:1]), .Trap(ctlA[0]),
        .InstrCount(cntA)
    );

    mc_fsm_controller #(.MEM_HANDSHAKE(1), .TRAP_EN(0), .CNT_W(4)) dutB (
        .clk(clk), .reset(rstB), .Op(opB), .MemReady(rdyB), .S(sB),
        .PCWrite(ctlB[19]), .PCWriteCond(ctlB[18]), .BranchNe(ctlB[17]), .IorD(ctlB[16]),
        .MemRead(ctlB[15]), .MemWrite(ctlB[14]), .IRWrite(ctlB[13]), .MemToReg(ctlB[12]),
        .RegDst(ctlB[11]), .RegWrite(ctlB[10]), .ALUSrcA(ctlB[9]), .ZeroExt(ctlB[8]),
        .ALUSrcB(ctlB[7:6]), .PCSource(ctlB[5:4]), .ALUOp(ctlB[3:1]), .Trap(ctlB[0]),
        .InstrCount(cntB)
    );

    // Control word expected in a given state, straight from the state output table
    function automatic logic [19:0] ctlFor(input logic [3:0] s, input logic [5:0] iop,
                                           input logic rdy, input bit h);
        logic pcw, pcc, bne, iord, mr, mw, irw, m2r, rd, rw, asa, ze, tr;
        logic [1:0] bsel, psrc;
        logic [2:0] aop;
        pcw = 0; pcc = 0; bne = 0; iord = 0; mr = 0; mw = 0; irw = 0;
        m2r = 0; rd = 0; rw = 0; asa = 0; ze = 0; tr = 0;
        bsel = 0; psrc = 0; aop = 0;
        case (s)
            4'd0: begin mr = 1; bsel = 2'b01; pcw = !h || rdy; irw = !h || rdy; end
            4'd1: bsel = 2'b11;
            4'd2: begin asa = 1; bsel = 2'b10; end
            4'd3: begin mr = 1; iord = 1; end
            4'd4: begin rw = 1; m2r = 1; end
            4'd5: begin mw = 1; iord = 1; end
            4'd6: begin asa = 1; aop = 3'b010; end
            4'd7: begin rd = 1; rw = 1; end
            4'd8, 4'd12: begin asa = 1; aop = 3'b001; pcc = 1; psrc = 2'b01; bne = (s == 4'd12); end
            4'd9: begin pcw = 1; psrc = 2'b10; end
            4'd10, 4'd11: begin
                aop = (iop == 6'd12) ? 3'b011 : (iop == 6'd13) ? 3'b100 : 3'b000;
                ze = (iop == 6'd12) || (iop == 6'd13);
                if (s == 4'd10) begin asa = 1; bsel = 2'b10; end else rw = 1;
            end
            4'd15: tr = 1;
            default: ;
        endcase
        return {pcw, pcc, bne, iord, mr, mw, irw, m2r, rd, rw, asa, ze, bsel, psrc, aop, tr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        exp_t r;
        @(negedge clk);
        if (q.size() > 0) begin
            r = q.pop_front();
            chk(r.dut ? "B.state" : "A.state", r.dut ? 32'(sB) : 32'(sA), 32'(r.s));
            chk(r.dut ? "B.controls" : "A.controls", r.dut ? 32'(ctlB) : 32'(ctlA), 32'(r.ctl));
            chk(r.dut ? "B.count" : "A.count", r.dut ? 32'(cntB) : 32'(cntA), 32'(r.cnt));
        end
    end

    task automatic step(input logic [3:0] s, input logic [5:0] iop, input bit opUsed, input logic rdy);
        exp_t r;
        if (cur) begin opB = opUsed ? iop : 6'($urandom); rdyB = rdy; end
        else begin opA = opUsed ? iop : 6'($urandom); rdyA = rdy; end
        r.dut = cur; r.s = s; r.ctl = ctlFor(s, iop, rdy, cur); r.cnt = cnt;
        q.push_back(r);
        @(posedge clk); #1;
    endtask

    task automatic resetNow(input logic [3:0] s);
        logic rdy = 1'($urandom);
        chk("pre-reset state", cur ? 32'(sB) : 32'(sA), 32'(s));
        if (cur) rdyB = rdy; else rdyA = rdy;
        #1;
        if (cur) rstB = 1'b1; else rstA = 1'b1;
        #1;
        chk("async reset state", cur ? 32'(sB) : 32'(sA), 32'd0);
        chk("async reset count", cur ? 32'(cntB) : 32'(cntA), 32'd0);
        chk("reset controls", cur ? 32'(ctlB) : 32'(ctlA), 32'(ctlFor(4'd0, 6'd0, rdy, cur)));
        @(posedge clk); #1;
        if (cur) rstB = 1'b0; else rstA = 1'b0;
        cnt = '0;
    endtask

    task automatic addHold(input logic [3:0] s, input int w);
        int n = (w < 0) ? int'($urandom_range(0, 3)) : w;
        if (cur) begin
            repeat (n) cyc.push_back({s, 1'b0});
            cyc.push_back({s, 1'b1});
        end else cyc.push_back({s, 1'($urandom)});
    endtask

    // One instruction: build its cycle-by-cycle state path, then drive it
    task automatic runInstr(input logic [5:0] op, input int fw = -1, input int mw = -1, input int cutState = -1);
        bit legalOp = op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd35, 6'd43};
        cyc.delete();
        addHold(4'd0, fw);
        cyc.push_back({4'd1, 1'b0});
        case (op)
            6'd0: begin cyc.push_back({4'd6, 1'b0}); cyc.push_back({4'd7, 1'b0}); end
            6'd35: begin cyc.push_back({4'd2, 1'b0}); addHold(4'd3, mw); cyc.push_back({4'd4, 1'b0}); end
            6'd43: begin cyc.push_back({4'd2, 1'b0}); addHold(4'd5, mw); end
            6'd4: cyc.push_back({4'd8, 1'b0});
            6'd5: cyc.push_back({4'd12, 1'b0});
            6'd2: cyc.push_back({4'd9, 1'b0});
            6'd8, 6'd12, 6'd13: begin cyc.push_back({4'd10, 1'b0}); cyc.push_back({4'd11, 1'b0}); end
            default: if (!cur) repeat (10) cyc.push_back({4'd15, 1'b0});
        endcase
        foreach (cyc[i]) begin
            if (int'(cyc[i][4:1]) == cutState) begin
                resetNow(cyc[i][4:1]);
                return;
            end
            step(cyc[i][4:1], op, cyc[i][4:1] inside {4'd1, 4'd2}, cyc[i][0]);
        end
        if (legalOp) cnt = (cnt + 16'd1) & (cur ? 16'h000F : 16'hFFFF);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        chk("A.reset state", 32'(sA), 32'd0);
        chk("A.reset count", 32'(cntA), 32'd0);
        chk("A.reset controls", 32'(ctlA), 32'(ctlFor(4'd0, 6'd0, 1'b0, 1'b0)));
        chk("B.reset state", 32'(sB), 32'd0);
        chk("B.reset controls", 32'(ctlB), 32'(ctlFor(4'd0, 6'd0, 1'b0, 1'b1)));
        rstA = 1'b0;
        cur = 1'b0;
        foreach (legal[i]) runInstr(legal[i]);
        runInstr(6'd12);
        repeat (120) runInstr(legal[$urandom_range(0, 8)]);
        runInstr(6'd0, -1, -1, 6);
        runInstr(6'd13);
        runInstr(6'd63);
        resetNow(4'd15);
        runInstr(6'd35);
        rstA = 1'b1;
        cur = 1'b1;
        cnt = '0;
        rstB = 1'b0;
        runInstr(6'd43, 3, 2);
        runInstr(6'd35);
        runInstr(6'd63);
        repeat (16) runInstr(6'd2);
        repeat (60) runInstr($urandom_range(0, 1) ? legal[$urandom_range(0, 8)] : 6'($urandom));
        if (cnt == 16'd0) runInstr(6'd2);
        runInstr(6'd35, -1, -1, 2);
        runInstr(6'd8);
        @(negedge clk); #1;
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mc_fsm_controller.md
MC_FSM_CONTROLLER -- requirements
Module: mc_fsm_controller

Interface
REQ-001 Parameters SHALL be: MEM_HANDSHAKE, default 0, 1 = memory states wait for MemReady; TRAP_EN, default 1, 1 = illegal opcode enters TRAP, 0 = illegal opcode returns to FETCH; CNT_W, default 16, width of the retired-instruction counter.
REQ-002 The design SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The ports SHALL be as follows, one per line (name  direction  width  meaning):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- Op  in  6  instruction opcode.
- MemReady  in  1  memory access completes this cycle.
- S  out  4  current state.
- PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, ZeroExt  out  1 each  datapath controls.
- ALUSrcB  out  2  00 regB, 01 const 4, 10 imm, 11 imm<<2.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- ALUOp  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or.
- Trap  out  1  illegal opcode halt.
- InstrCount  out  CNT_W  count of retired instructions.

Function
REQ-004 State SHALL be held in an internal 4-bit register. Encodings: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC_R, 7 RWB, 8 BEQ, 9 JUMP, 10 IEXEC, 11 IWB, 12 BNE, 15 TRAP; 13/14 are unused.
REQ-005 Transitions SHALL be:
- FETCH->DECODE.
- DECODE dispatches on Op: 0->EXEC_R, 35/43->MEMADR, 4->BEQ, 5->BNE, 2->JUMP, 8/12/13->IEXEC, others->TRAP if TRAP_EN else FETCH.
- MEMADR: Op 35->MEMRD, Op 43->MEMWR.
- MEMRD->MEMWB; EXEC_R->RWB; IEXEC->IWB.
- MEMWB, MEMWR, RWB, IWB, BEQ, BNE, JUMP->FETCH.
- TRAP->TRAP.
- Unused encodings 13/14->FETCH.
REQ-006 Outputs SHALL be a Moore decode of S, except for the MemReady qualification in REQ-008; every signal not listed for a state is 0:
- FETCH: MemRead, IRWrite, ALUSrcB=01, PCWrite.
- DECODE: ALUSrcB=11.
- MEMADR: ALUSrcA, ALUSrcB=10.
- MEMRD: MemRead, IorD.
- MEMWB: RegWrite, MemToReg.
- MEMWR: MemWrite, IorD.
- EXEC_R: ALUSrcA, ALUOp=010.
- RWB: RegDst, RegWrite.
- BEQ: ALUSrcA, ALUOp=001, PCWriteCond, PCSource=01.
- BNE: same as BEQ plus BranchNe.
- JUMP: PCWrite, PCSource=10.
- IEXEC: ALUSrcA, ALUSrcB=10; ALUOp=000 for Op 8, 011 for Op 12, 100 for Op 13; ZeroExt=1 for Op 12/13.
- IWB: RegWrite; ALUOp and ZeroExt held as in IEXEC.
- TRAP: Trap=1.
REQ-007 With MEM_HANDSHAKE=0, MemReady SHALL be ignored and every state SHALL last exactly one cycle.
REQ-008 With MEM_HANDSHAKE=1, FETCH, MEMRD and MEMWR SHALL hold while MemReady=0. MemRead/MemWrite/IorD stay asserted throughout the hold. PCWrite and IRWrite in FETCH are asserted only in the cycle MemReady=1.
REQ-009 InstrCount SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, IWB, BEQ, BNE or JUMP, and wrap modulo 2^CNT_W.
REQ-010 InstrCount SHALL NOT increment on illegal-opcode returns (TRAP_EN=0) or on recovery from unused encodings.
REQ-011 Op SHALL be sampled only in DECODE and MEMADR; Op changes in other states SHALL have no effect.

Reset
REQ-012 When reset is asserted, S SHALL go to FETCH and InstrCount to 0 immediately, without waiting for a clock edge, including mid-instruction and from TRAP.
REQ-013 During reset, outputs SHALL show the FETCH decode, with PCWrite/IRWrite gated by MemReady when MEM_HANDSHAKE=1.
REQ-014 Reset SHALL be the only exit from TRAP.

Verification
REQ-015 Defaults, Op=35 after reset: S sequence 0,1,2,3,4,0 over 5 cycles; MemToReg=1 and RegWrite=1 in state 4; InstrCount=1.
REQ-016 Op=0 then Op=5: S sequence 0,1,6,7,0,1,12,0; BranchNe=1 and PCWriteCond=1 in state 12; InstrCount=2.
REQ-017 Op=13: S sequence 0,1,10,11,0 with ALUOp=100 and ZeroExt=1 in states 10 and 11; Op=12 gives ALUOp=011.
REQ-018 MEM_HANDSHAKE=1, Op=43, MemReady low for 3 cycles in FETCH and 2 cycles in MEMWR: FETCH lasts 4 cycles with PCWrite=1 only in the last; MEMWR lasts 3 cycles with MemWrite=1 throughout.
REQ-019 Op=63: TRAP_EN=1 gives S=15 and Trap=1 held for 10 cycles; asserting reset gives S=0 at once. TRAP_EN=0 gives S back to 0 with InstrCount unchanged.
REQ-020 CNT_W=4, 16 Op=2 instructions: InstrCount wraps from 15 to 0; reset asserted in state 2 gives S=0 and InstrCount=0 before the next clock edge.
